param_vending_fsm: RTL
======================

Name: param_vending_fsm

Overview:
Parametrised Mealy vending controller; successor to the two-coin fixed-price vending FSM. It accumulates credit from two coin inputs of configurable value and vends when credit reaches a configurable price. It returns excess or cancelled credit as a sequence of unit-coin change pulses and tracks item stock with sold-out and restock handling. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

Parameters:
PRICE, 15, item price in credit units
VAL_A, 5, value of coin_a (the change unit coin)
VAL_B, 10, value of coin_b
CREDIT_W, 5, credit register width; must hold PRICE-1+VAL_A+VAL_B
STOCK_INIT, 3, items loaded at reset/restock
STOCK_W, 4, stock counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
coin_a  in  1  one VAL_A coin this cycle (single-cycle pulse)
coin_b  in  1  one VAL_B coin this cycle
cancel  in  1  refund current credit
restock  in  1  reload stock to STOCK_INIT
vend  out  1  Mealy dispense pulse, combinational in the purchase cycle
change  out  1  one VAL_A coin returned per asserted cycle
coin_accept  out  1  high when coins are counted (state COLLECT)
sold_out  out  1  high in state SOLDOUT
credit  out  CREDIT_W  current accumulated credit
stock  out  STOCK_W  items remaining

Behaviour:
- Reset (rst low, async): state COLLECT, or SOLDOUT if STOCK_INIT==0. credit=0, rem=0, stock=STOCK_INIT. vend and change are forced to 0 while rst is low.
- Constraints (elaboration-checked): VAL_B and PRICE are multiples of VAL_A; VAL_A>0.
- sum = credit + (coin_a?VAL_A:0) + (coin_b?VAL_B:0), computed at CREDIT_W+1 bits. Simultaneous coin_a and coin_b are both counted.
- States: COLLECT, CHANGE, SOLDOUT.
- COLLECT, by priority:
  - cancel: vend=0. If sum==0, stay. Otherwise rem<=sum, credit<=0, go to CHANGE. Coins arriving in the cancel cycle are refunded.
  - sum>=PRICE: vend=1 in the same cycle. stock<=stock-1, credit<=0, rem<=sum-PRICE. If rem!=0, go to CHANGE. Otherwise go to SOLDOUT if the new stock is 0, else stay in COLLECT.
  - else: credit<=sum.
- CHANGE: change=1 every cycle; rem<=rem-VAL_A. Coins are ignored (coin_accept=0); cancel is ignored. On the cycle where rem==VAL_A (last pulse), go to SOLDOUT if stock==0, else COLLECT. Change pulse count = refund/VAL_A, with no gaps.
- SOLDOUT: coins and cancel are ignored; credit stays 0.
- restock, any state: stock<=STOCK_INIT at the next edge.
  - SOLDOUT with restock: COLLECT next cycle.
  - CHANGE with restock: change sequence completes, then COLLECT.
  - Restock coincident with a vend: reload wins, stock=STOCK_INIT.
- No vend ever occurs with stock==0. vend stays combinational (Mealy) and depends on coin inputs only in COLLECT.
- All other state updates occur on the rising clk edge.

Decomposition:
- Shared package vending_pkg holds:
  - state encoding localparams (COLLECT=2'd0, CHANGE=2'd1, SOLDOUT=2'd2)
  - default price and coin values.
- One sub-module, vend_change_ctr:
  - loadable down-counter by VAL_A
  - ports: clk, rst, load, load_val, busy, last
  - drives change.
- Credit adder and FSM stay in the top level.

Test Plan:
- Reset, then coin_b, then coin_a on consecutive cycles -> vend=1 combinationally in the coin_a cycle; credit 10 then 0; stock 3->2; change never asserted.
- coin_b, coin_b -> vend in 2nd cycle; exactly 1 change pulse next cycle; coin_accept=0 during it; credit=0; stock 2.
- coin_b, then coin_a+coin_b in the same cycle (sum 25) -> vend, then 2 consecutive change pulses, return to COLLECT.
- coin_a, coin_a, then cancel -> no vend; 2 change pulses; stock unchanged. Cancel with credit 0 -> no change pulse.
- Three purchases from reset -> stock 0, sold_out=1, coin_a ignored (credit stays 0). restock pulse -> next cycle coin_accept=1, stock=3.
- rst low mid-CHANGE (rem=10) -> change drops immediately; credit=0, stock=3, state COLLECT. After release, no residual change pulses.

Source files
------------

// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the parametrised vending controller:
//   - state encoding (COLLECT / CHANGE / SOLDOUT) and matching enum type
//   - default price, coin values and register widths
// -----------------------------------------------------------------------------
package vending_pkg;

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] CHANGE  = 2'd1;
  localparam logic [1:0] SOLDOUT = 2'd2;

  typedef enum logic [1:0] {
    S_COLLECT = COLLECT,
    S_CHANGE  = CHANGE,
    S_SOLDOUT = SOLDOUT
  } state_e;

  localparam int DEF_PRICE      = 15;
  localparam int DEF_VAL_A      = 5;
  localparam int DEF_VAL_B      = 10;
  localparam int DEF_CREDIT_W   = 5;
  localparam int DEF_STOCK_INIT = 3;
  localparam int DEF_STOCK_W    = 4;

endpackage

// File: rtl/vend_change_ctr.sv
// -----------------------------------------------------------------------------
// vend_change_ctr
// Loadable down-counter holding the credit still to be refunded. Each cycle
// it is non-zero one unit coin (STEP) is paid out and subtracted.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset (clears the remainder)
//   load     in   capture load_val as the new remainder
//   load_val in   W  amount to refund (multiple of STEP)
//   busy     out  remainder non-zero: a change coin is paid this cycle
//   last     out  remainder equals STEP: this is the final change coin
// -----------------------------------------------------------------------------
module vend_change_ctr #(
  parameter int W    = 6,
  parameter int STEP = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         last
);

  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] rem_q, rem_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rem_q <= '0;
    else      rem_q <= rem_d;
  end

  always_comb begin
    rem_d = rem_q;
    if (load)      rem_d = load_val;
    else if (busy) rem_d = rem_q - STEP_W;
  end

  assign busy = (rem_q != '0);
  assign last = (rem_q == STEP_W);

endmodule

// File: rtl/param_vending_fsm.sv
// -----------------------------------------------------------------------------
// param_vending_fsm
// Mealy vending controller: accumulates credit from two coin inputs, vends
// combinationally when credit reaches PRICE, refunds excess or cancelled
// credit as back-to-back unit-coin (VAL_A) change pulses, tracks stock.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   coin_a      in   one VAL_A coin this cycle
//   coin_b      in   one VAL_B coin this cycle
//   cancel      in   refund current credit (plus coins of this cycle)
//   restock     in   reload stock to STOCK_INIT at the next edge
//   vend        out  dispense pulse, combinational in the purchase cycle
//   change      out  one VAL_A coin returned per asserted cycle
//   coin_accept out  coins are being counted (COLLECT)
//   sold_out    out  no stock and no refund pending (SOLDOUT)
//   credit      out  accumulated credit
//   stock       out  items remaining
//   state_dbg   out  current FSM state encoding
// Handshake: the coin/cancel/restock inputs are single-cycle pulses sampled
// every rising edge; there is no back-pressure, coin_accept only reports
// whether a coin presented this cycle will be counted.
// -----------------------------------------------------------------------------
module param_vending_fsm
  import vending_pkg::*;
#(
  parameter int PRICE      = DEF_PRICE,
  parameter int VAL_A      = DEF_VAL_A,
  parameter int VAL_B      = DEF_VAL_B,
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int STOCK_INIT = DEF_STOCK_INIT,
  parameter int STOCK_W    = DEF_STOCK_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_a,
  input  logic                coin_b,
  input  logic                cancel,
  input  logic                restock,
  output logic                vend,
  output logic                change,
  output logic                coin_accept,
  output logic                sold_out,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock,
  output logic [1:0]          state_dbg
);

  localparam int SUM_W = CREDIT_W + 1;

  localparam logic [SUM_W-1:0]   PRICE_S  = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0]   VAL_A_S  = SUM_W'(VAL_A);
  localparam logic [SUM_W-1:0]   VAL_B_S  = SUM_W'(VAL_B);
  localparam logic [STOCK_W-1:0] STOCK_RL = STOCK_W'(STOCK_INIT);
  localparam state_e             RST_ST   = (STOCK_INIT == 0) ? S_SOLDOUT : S_COLLECT;

  // Parameter sanity: refunds are paid in VAL_A coins, so every amount that
  // can be refunded must be a whole number of them.
  if (VAL_A <= 0) begin : g_bad_val_a
    $error("param_vending_fsm: VAL_A must be positive");
  end else if ((VAL_B % VAL_A) != 0 || (PRICE % VAL_A) != 0) begin : g_bad_mult
    $error("param_vending_fsm: VAL_B and PRICE must be multiples of VAL_A");
  end
  if ((PRICE - 1 + VAL_A + VAL_B) >= (1 << CREDIT_W)) begin : g_bad_width
    $error("param_vending_fsm: CREDIT_W too small for worst-case credit");
  end

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [STOCK_W-1:0]   stock_q, stock_d;
  logic [SUM_W-1:0]     sum, sum_less;
  logic                 vend_raw;
  logic                 ctr_load;
  logic [SUM_W-1:0]     ctr_val;
  logic                 ctr_busy, ctr_last;

  // One extra bit so credit plus both coins never wraps before the compare.
  assign sum      = {1'b0, credit_q}
                  + (coin_a ? VAL_A_S : '0)
                  + (coin_b ? VAL_B_S : '0);
  assign sum_less = sum - PRICE_S;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RST_ST;
      credit_q <= '0;
      stock_q  <= STOCK_RL;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      stock_q  <= stock_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    vend_raw = 1'b0;
    ctr_load = 1'b0;
    ctr_val  = sum;
    // A restock wins over any decrement in the same cycle.
    stock_d  = restock ? STOCK_RL : stock_q;

    case (state_q)
      S_COLLECT: begin
        if (cancel) begin
          if (sum != '0) begin
            ctr_load = 1'b1;
            credit_d = '0;
            state_d  = S_CHANGE;
          end
        end else if (sum >= PRICE_S && stock_q != '0) begin
          vend_raw = 1'b1;
          credit_d = '0;
          ctr_val  = sum_less;
          if (!restock) stock_d = stock_q - STOCK_W'(1);
          if (sum_less != '0) begin
            ctr_load = 1'b1;
            state_d  = S_CHANGE;
          end else if (stock_d == '0) begin
            state_d  = S_SOLDOUT;
          end
        end else begin
          credit_d = sum[CREDIT_W-1:0];
        end
      end
      S_CHANGE: begin
        if (ctr_last) state_d = (stock_d == '0) ? S_SOLDOUT : S_COLLECT;
      end
      S_SOLDOUT: begin
        if (stock_d != '0) state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  vend_change_ctr #(
    .W    (SUM_W),
    .STEP (VAL_A)
  ) u_change_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_val),
    .busy     (ctr_busy),
    .last     (ctr_last)
  );

  // Both pulses are explicitly qualified by rst so they drop the moment reset
  // asserts, without waiting for any register to clear.
  assign vend        = vend_raw & rst;
  assign change      = ctr_busy & rst;
  assign coin_accept = (state_q == S_COLLECT);
  assign sold_out    = (state_q == S_SOLDOUT);
  assign credit      = credit_q;
  assign stock       = stock_q;
  assign state_dbg   = state_q;

endmodule
